// File: rtl/pzcorebus_simple_responder_if.sv
// Memory-profile pzcorebus bundle between a command/data master and a responder.
// Valid/ready rule for all three channels: a transfer happens on a rising clock
// edge where the producer's valid and the consumer's accept are both high; the
// producer holds every payload field stable while valid is high and accept is low.
interface pzcorebus_simple_responder_if #(
   parameter int ID_WIDTH      = 8,
   parameter int ADDRESS_WIDTH = 32,
   parameter int LENGTH_WIDTH  = 5,
   parameter int DATA_WIDTH    = 64
);
   // command channel
   logic                     mcmd_valid;
   logic                     scmd_accept;
   logic [3:0]               mcmd;
   logic [ID_WIDTH-1:0]      mid;
   logic [ADDRESS_WIDTH-1:0] maddr;
   logic [LENGTH_WIDTH-1:0]  mlength;
   // write data channel (payload itself is discarded by the responder)
   logic                     mdata_valid;
   logic                     sdata_accept;
   logic                     mdata_last;
   // response channel
   logic                     sresp_valid;
   logic                     mresp_accept;
   logic [1:0]               sresp;
   logic [ID_WIDTH-1:0]      sresp_id;
   logic [DATA_WIDTH-1:0]    sresp_data;
   logic                     sresp_last;

   modport master (
      output mcmd_valid, mcmd, mid, maddr, mlength,
      output mdata_valid, mdata_last,
      output mresp_accept,
      input  scmd_accept, sdata_accept,
      input  sresp_valid, sresp, sresp_id, sresp_data, sresp_last
   );

   modport slave (
      input  mcmd_valid, mcmd, mid, maddr, mlength,
      input  mdata_valid, mdata_last,
      input  mresp_accept,
      output scmd_accept, sdata_accept,
      output sresp_valid, sresp, sresp_id, sresp_data, sresp_last
   );
endinterface

// File: rtl/pzcorebus_simple_responder.sv
// Terminating slave for a memory-profile pzcorebus: accepts every command, sinks
// write data, and returns in-order responses (id, type, beat count, last flag)
// for each non-posted command. Response data carries the 0-based beat index.
module pzcorebus_simple_responder #(
   parameter int ID_WIDTH        = 8,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int LENGTH_WIDTH    = 5,
   parameter int MAX_LENGTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int UNIT_DATA_WIDTH = 32,
   parameter int CMD_DEPTH       = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   pzcorebus_simple_responder_if.slave   bus,
   output logic                          dbg_req_state,
   output logic                          dbg_rsp_state
);
   // command encodings: bit3 = non-posted, bit2 = carries write data (READ excepted)
   localparam logic [3:0] CMD_READ              = 4'b1000;
   localparam logic [3:0] CMD_MESSAGE           = 4'b0100;
   localparam logic [3:0] CMD_WRITE             = 4'b0101;
   localparam logic [3:0] CMD_FULL_WRITE        = 4'b0110;
   localparam logic [3:0] CMD_BROADCAST         = 4'b0111;
   localparam logic [3:0] CMD_MESSAGE_NP        = 4'b1100;
   localparam logic [3:0] CMD_WRITE_NP          = 4'b1101;
   localparam logic [3:0] CMD_FULL_WRITE_NP     = 4'b1110;
   localparam logic [3:0] CMD_BROADCAST_NP      = 4'b1111;
   localparam logic [1:0] RESP_RESPONSE         = 2'b10;
   localparam logic [1:0] RESP_RESPONSE_DATA    = 2'b11;

   localparam int DATA_BYTE    = DATA_WIDTH / 8;
   localparam int UNIT_BYTE    = UNIT_DATA_WIDTH / 8;
   localparam int OFFSET_WIDTH = $clog2(DATA_BYTE);
   localparam int UNIT_SHIFT   = $clog2(UNIT_BYTE);
   localparam int RATIO        = DATA_WIDTH / UNIT_DATA_WIDTH;
   localparam int BEAT_WIDTH   = $clog2(MAX_LENGTH + RATIO) + 1;
   localparam int PTR_WIDTH    = $clog2(CMD_DEPTH);
   localparam int COUNT_WIDTH  = PTR_WIDTH + 1;

   typedef enum logic {REQ_IDLE = 1'b0, REQ_DATA = 1'b1} req_state_t;
   typedef enum logic {RSP_IDLE = 1'b0, RSP_BUSY = 1'b1} rsp_state_t;

   function automatic logic is_non_posted(input logic [3:0] cmd);
      logic result;
      case (cmd)
         CMD_READ, CMD_MESSAGE_NP, CMD_WRITE_NP,
         CMD_FULL_WRITE_NP, CMD_BROADCAST_NP: result = 1'b1;
         default:                             result = 1'b0;
      endcase
      return result;
   endfunction

   function automatic logic has_data(input logic [3:0] cmd);
      logic result;
      case (cmd)
         CMD_MESSAGE, CMD_WRITE, CMD_FULL_WRITE, CMD_BROADCAST,
         CMD_MESSAGE_NP, CMD_WRITE_NP, CMD_FULL_WRITE_NP,
         CMD_BROADCAST_NP: result = 1'b1;
         default:          result = 1'b0;
      endcase
      return result;
   endfunction

   function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == PTR_WIDTH'(CMD_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   req_state_t                req_state;
   rsp_state_t                rsp_state;
   logic                      scmd_accept_q;
   logic                      sdata_accept_q;

   // non-posted command queue
   logic [3:0]                cmd_q  [CMD_DEPTH];
   logic [ID_WIDTH-1:0]       id_q   [CMD_DEPTH];
   logic [OFFSET_WIDTH-1:0]   addr_q [CMD_DEPTH];
   logic [LENGTH_WIDTH-1:0]   len_q  [CMD_DEPTH];
   logic [PTR_WIDTH-1:0]      wr_ptr;
   logic [PTR_WIDTH-1:0]      rd_ptr;
   logic [COUNT_WIDTH-1:0]    count;
   logic [COUNT_WIDTH-1:0]    count_next;
   logic                      full_next;

   // response registers
   logic                      sresp_valid_q;
   logic [1:0]                sresp_q;
   logic [ID_WIDTH-1:0]       sresp_id_q;
   logic [DATA_WIDTH-1:0]     sresp_data_q;
   logic                      sresp_last_q;
   logic [BEAT_WIDTH-1:0]     beat;
   logic [BEAT_WIDTH-1:0]     beats;

   logic                      cmd_ack;
   logic                      last_data_ack;
   logic                      push;
   logic                      pop;
   logic [BEAT_WIDTH-1:0]     head_len;
   logic [BEAT_WIDTH-1:0]     head_offset;
   logic [BEAT_WIDTH-1:0]     head_beats;
   logic [1:0]                head_type;

   // Only the in-beat byte offset of the address shapes a response.
   logic unused_addr;
   assign unused_addr = ^bus.maddr[ADDRESS_WIDTH-1:OFFSET_WIDTH];

   assign cmd_ack       = bus.mcmd_valid && scmd_accept_q;
   assign last_data_ack = bus.mdata_valid && sdata_accept_q && bus.mdata_last;
   assign push          = cmd_ack && is_non_posted(bus.mcmd);
   assign pop           = (rsp_state == RSP_BUSY) && bus.mresp_accept && sresp_last_q;

   // Occupancy after this edge; accept for the next cycle is derived from it so a
   // same-cycle pop never reopens a full queue within that cycle.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
      full_next = (count_next == COUNT_WIDTH'(CMD_DEPTH));
   end

   // Request FSM: take commands in REQ_IDLE, swallow write beats in REQ_DATA.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_state      <= REQ_IDLE;
         scmd_accept_q  <= 1'b0;
         sdata_accept_q <= 1'b0;
      end else begin
         case (req_state)
            REQ_IDLE: begin
               if (cmd_ack && has_data(bus.mcmd)) begin
                  req_state      <= REQ_DATA;
                  scmd_accept_q  <= 1'b0;
                  sdata_accept_q <= 1'b1;
               end else begin
                  scmd_accept_q  <= !full_next;
                  sdata_accept_q <= 1'b0;
               end
            end
            REQ_DATA: begin
               if (last_data_ack) begin
                  req_state      <= REQ_IDLE;
                  scmd_accept_q  <= !full_next;
                  sdata_accept_q <= 1'b0;
               end else begin
                  scmd_accept_q  <= 1'b0;
                  sdata_accept_q <= 1'b1;
               end
            end
            default: begin
               req_state      <= REQ_IDLE;
               scmd_accept_q  <= 1'b0;
               sdata_accept_q <= 1'b0;
            end
         endcase
      end
   end

   // Queue payload storage; contents are only meaningful below count.
   always_ff @(posedge i_clk) begin
      if (push) begin
         cmd_q[wr_ptr]  <= bus.mcmd;
         id_q[wr_ptr]   <= bus.mid;
         addr_q[wr_ptr] <= bus.maddr[OFFSET_WIDTH-1:0];
         len_q[wr_ptr]  <= bus.mlength;
      end
   end

   // Queue pointers and occupancy, wrapping at CMD_DEPTH.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count_next;
      end
   end

   // Beat count and response type of the queue head.
   always_comb begin
      head_len    = (len_q[rd_ptr] == '0) ? BEAT_WIDTH'(MAX_LENGTH) : BEAT_WIDTH'(len_q[rd_ptr]);
      head_offset = BEAT_WIDTH'(addr_q[rd_ptr] >> UNIT_SHIFT);
      head_beats  = BEAT_WIDTH'(1);
      head_type   = RESP_RESPONSE;
      if (cmd_q[rd_ptr] == CMD_READ) begin
         head_beats = (head_len + head_offset + BEAT_WIDTH'(RATIO - 1)) / BEAT_WIDTH'(RATIO);
      end
      if ((cmd_q[rd_ptr] == CMD_READ) || (cmd_q[rd_ptr] == CMD_MESSAGE_NP)) begin
         head_type = RESP_RESPONSE_DATA;
      end
   end

   // Response FSM: load head, stream beats, pop on last ack with a one-cycle gap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_state     <= RSP_IDLE;
         sresp_valid_q <= 1'b0;
         sresp_q       <= '0;
         sresp_id_q    <= '0;
         sresp_data_q  <= '0;
         sresp_last_q  <= 1'b0;
         beat          <= '0;
         beats         <= '0;
      end else begin
         case (rsp_state)
            RSP_IDLE: begin
               if (count != '0) begin
                  rsp_state     <= RSP_BUSY;
                  sresp_valid_q <= 1'b1;
                  sresp_q       <= head_type;
                  sresp_id_q    <= id_q[rd_ptr];
                  sresp_data_q  <= '0;
                  sresp_last_q  <= (head_beats == BEAT_WIDTH'(1));
                  beat          <= BEAT_WIDTH'(1);
                  beats         <= head_beats;
               end
            end
            RSP_BUSY: begin
               if (bus.mresp_accept) begin
                  if (sresp_last_q) begin
                     rsp_state     <= RSP_IDLE;
                     sresp_valid_q <= 1'b0;
                     sresp_q       <= '0;
                     sresp_id_q    <= '0;
                     sresp_data_q  <= '0;
                     sresp_last_q  <= 1'b0;
                  end else begin
                     beat          <= beat + 1'b1;
                     sresp_data_q  <= DATA_WIDTH'(beat);
                     sresp_last_q  <= ((beat + 1'b1) == beats);
                  end
               end
            end
            default: begin
               rsp_state     <= RSP_IDLE;
               sresp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.scmd_accept  = scmd_accept_q;
   assign bus.sdata_accept = sdata_accept_q;
   assign bus.sresp_valid  = sresp_valid_q;
   assign bus.sresp        = sresp_q;
   assign bus.sresp_id     = sresp_id_q;
   assign bus.sresp_data   = sresp_data_q;
   assign bus.sresp_last   = sresp_last_q;
   assign dbg_req_state    = req_state;
   assign dbg_rsp_state    = rsp_state;
endmodule

// File: tb/tb_pzcorebus_simple_responder.sv
// Directed bench for pzcorebus_simple_responder: expected response beats are queued
// when commands are driven and checked as the responder hands them over.
module tb_pzcorebus_simple_responder;
   localparam int ID_W   = 8;
   localparam int AW     = 32;
   localparam int LW     = 5;
   localparam int DW     = 64;
   localparam int EW     = 2 + ID_W + DW + 1;

   localparam logic [3:0] C_READ          = 4'b1000;
   localparam logic [3:0] C_WRITE         = 4'b0101;
   localparam logic [3:0] C_MESSAGE_NP    = 4'b1100;
   localparam logic [3:0] C_WRITE_NP      = 4'b1101;
   localparam logic [3:0] C_FULL_WRITE_NP = 4'b1110;
   localparam logic [3:0] C_BROADCAST_NP  = 4'b1111;
   localparam logic [1:0] R_RESP          = 2'b10;
   localparam logic [1:0] R_RESP_DATA     = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dbg_req;
   logic dbg_rsp;
   int n_cmp = 0;
   int n_bad = 0;
   logic [EW-1:0] exp_q[$];
   bit prev_stall = 1'b0;
   logic [EW-1:0] prev_pack = '0;

   pzcorebus_simple_responder_if #(
      .ID_WIDTH(ID_W), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW), .DATA_WIDTH(DW)
   ) bus ();

   pzcorebus_simple_responder #(
      .ID_WIDTH(ID_W), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW), .MAX_LENGTH(32),
      .DATA_WIDTH(DW), .UNIT_DATA_WIDTH(32), .CMD_DEPTH(4)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus),
      .dbg_req_state(dbg_req),
      .dbg_rsp_state(dbg_rsp)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] pack_beat(input logic [1:0] r, input logic [7:0] id,
                                                input int idx, input logic last);
      return {r, id, DW'(idx), last};
   endfunction

   function automatic logic [EW-1:0] cur_pack();
      return {bus.sresp, bus.sresp_id, bus.sresp_data, bus.sresp_last};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: beats queued for one command
   task automatic expect_cmd(input logic [3:0] cmd, input logic [7:0] id,
                             input logic [31:0] addr, input logic [4:0] len);
      int offset;
      int l;
      int nb;
      if (cmd == C_READ) begin
         offset = int'(addr % 8) / 4;
         l = (len == 0) ? 32 : int'(len);
         nb = (l + offset + 1) / 2;
         for (int b = 0; b < nb; b++) exp_q.push_back(pack_beat(R_RESP_DATA, id, b, b == nb - 1));
      end else if (cmd == C_MESSAGE_NP) begin
         exp_q.push_back(pack_beat(R_RESP_DATA, id, 0, 1'b1));
      end else if (cmd[3]) begin
         exp_q.push_back(pack_beat(R_RESP, id, 0, 1'b1));
      end
   endtask

   task automatic send_cmd(input logic [3:0] cmd, input logic [7:0] id,
                           input logic [31:0] addr, input logic [4:0] len);
      bit got;
      got = 1'b0;
      expect_cmd(cmd, id, addr, len);
      bus.mcmd = cmd;
      bus.mid = id;
      bus.maddr = addr;
      bus.mlength = len;
      bus.mcmd_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.scmd_accept === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("cmd_accepted", got, 1'b1);
      tick();
      bus.mcmd_valid = 1'b0;
   endtask

   task automatic send_data(input int n);
      bit got;
      for (int b = 0; b < n; b++) begin
         got = 1'b0;
         bus.mdata_valid = 1'b1;
         bus.mdata_last = (b == n - 1);
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.sdata_accept === 1'b1) begin
               got = 1'b1;
               break;
            end
         end
         check("data_accepted", got, 1'b1);
         tick();
      end
      bus.mdata_valid = 1'b0;
      bus.mdata_last = 1'b0;
   endtask

   task automatic wait_drain(input bit random_accept);
      for (int i = 0; i < 2000; i++) begin
         if (exp_q.size() == 0) break;
         bus.mresp_accept = random_accept ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      check("drained", exp_q.size(), 0);
      bus.mresp_accept = 1'b1;
      repeat (2) tick();
   endtask

   function automatic logic [79:0] all_outputs();
      return {bus.scmd_accept, bus.sdata_accept, bus.sresp_valid, bus.sresp, bus.sresp_id,
              bus.sresp_data, bus.sresp_last, dbg_req, dbg_rsp};
   endfunction

   // scoreboard: pop on each response handshake, enforce hold during stalls
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("resp_hold", {bus.sresp_valid, cur_pack()}, {1'b1, prev_pack});
         end
         if (bus.sresp_valid === 1'b1 && bus.mresp_accept === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_bad++;
               $error("FAIL unexpected_resp: observed %0h expected none", cur_pack());
            end
            if (exp_q.size() != 0) begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               n_cmp++;
               assert (cur_pack() === e) else begin
                  n_bad++;
                  $error("FAIL resp_beat: observed %0h expected %0h", cur_pack(), e);
               end
            end
         end
         prev_stall = (bus.sresp_valid === 1'b1) && (bus.mresp_accept !== 1'b1);
         prev_pack = cur_pack();
      end
   end

   initial begin
      bit seen;
      bus.mcmd_valid = 1'b0;
      bus.mcmd = '0;
      bus.mid = '0;
      bus.maddr = '0;
      bus.mlength = '0;
      bus.mdata_valid = 1'b0;
      bus.mdata_last = 1'b0;
      bus.mresp_accept = 1'b0;

      // reset
      rst_n = 1'b0;
      repeat (3) tick();
      check("reset_outputs", all_outputs(), '0);
      rst_n = 1'b1;
      check("accept_before_edge", bus.scmd_accept, 1'b0);
      tick();
      check("accept_after_release", bus.scmd_accept, 1'b1);

      // data ahead of its command is held off
      bus.mdata_valid = 1'b1;
      bus.mdata_last = 1'b1;
      repeat (3) begin
         tick();
         check("data_holdoff", bus.sdata_accept, 1'b0);
      end
      bus.mdata_valid = 1'b0;
      bus.mdata_last = 1'b0;

      // READ id=3 addr=4 len=4 -> 3 beats, latency N+2, stalled first beat
      bus.mresp_accept = 1'b0;
      send_cmd(C_READ, 8'd3, 32'h4, 5'd4);
      check("latency_n1", bus.sresp_valid, 1'b0);
      tick();
      check("latency_n2", bus.sresp_valid, 1'b1);
      repeat (3) tick();
      wait_drain(1'b0);

      // WRITE_NON_POSTED id=7 len=2 with a single last data beat
      send_cmd(C_WRITE_NP, 8'd7, 32'h40, 5'd2);
      check("wnp_cmd_blocked", {bus.scmd_accept, bus.sdata_accept, dbg_req}, 3'b011);
      send_data(1);
      check("wnp_cmd_reopen", {bus.scmd_accept, bus.sdata_accept, dbg_req}, 3'b100);
      wait_drain(1'b0);

      // posted WRITE: no response at all
      send_cmd(C_WRITE, 8'd9, 32'h0, 5'd3);
      send_data(3);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (bus.sresp_valid === 1'b1) seen = 1'b1;
      end
      check("posted_no_resp", seen, 1'b0);

      // response types across non-posted commands
      send_cmd(C_MESSAGE_NP, 8'd20, 32'h0, 5'd1);
      send_data(1);
      send_cmd(C_BROADCAST_NP, 8'd21, 32'h0, 5'd1);
      send_data(1);
      send_cmd(C_FULL_WRITE_NP, 8'd22, 32'h8, 5'd2);
      send_data(2);
      send_cmd(C_READ, 8'd23, 32'h0, 5'd3);
      wait_drain(1'b1);

      // fill the queue with responses stalled
      bus.mresp_accept = 1'b0;
      send_cmd(C_READ, 8'd10, 32'h0, 5'd1);
      send_cmd(C_READ, 8'd11, 32'h4, 5'd1);
      send_cmd(C_READ, 8'd12, 32'h0, 5'd3);
      send_cmd(C_READ, 8'd13, 32'h4, 5'd2);
      check("full_after_4", bus.scmd_accept, 1'b0);
      bus.mcmd = C_READ;
      bus.mid = 8'd14;
      bus.maddr = 32'hC;
      bus.mlength = 5'd5;
      bus.mcmd_valid = 1'b1;
      repeat (5) begin
         tick();
         check("full_blocks", bus.scmd_accept, 1'b0);
      end
      bus.mresp_accept = 1'b1;
      send_cmd(C_READ, 8'd14, 32'hC, 5'd5);
      wait_drain(1'b1);

      // maximum-length READ interrupted by reset at beat 5
      bus.mresp_accept = 1'b1;
      send_cmd(C_READ, 8'd30, 32'h0, 5'd0);
      check("max_len_beats", exp_q.size(), 16);
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() <= 12) break;
         tick();
      end
      check("reached_beat5", {bus.sresp_valid, bus.sresp_data[7:0], 32'(exp_q.size())},
            {1'b1, 8'd4, 32'd12});
      rst_n = 1'b0;
      #1;
      check("reset_mid_burst", all_outputs(), '0);
      exp_q.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (bus.sresp_valid === 1'b1) seen = 1'b1;
      end
      check("no_stale_resp", seen, 1'b0);
      check("accept_after_reset", bus.scmd_accept, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
